// File: rtl/systolic_seq.sv
// Job sequencer for a size x size systolic MAC array: streams K lockstep X/W beats
// into the array, waits out the drain interval, then reads the result matrix row-major.
//   state | meaning
//   LOAD  | accepting beats, forwarding X/W to the array
//   DRAIN | waiting for the array pipeline to settle
//   READ  | streaming results out on the val/rdy port
module systolic_seq #(
  parameter int size   = 4,
  parameter int nbits  = 16,
  parameter int nbeats = 4,
  parameter int drain  = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [size-1:0][nbits-1:0]      in_x_col,
  input  logic [size-1:0][nbits-1:0]      in_w_row,
  input  logic                            in_val,
  output logic                            in_rdy,
  output logic [size-1:0][nbits-1:0]      arr_x_col,
  output logic                            arr_x_val,
  input  logic                            arr_x_rdy,
  output logic [size-1:0][nbits-1:0]      arr_w_row,
  output logic                            arr_w_val,
  input  logic                            arr_w_rdy,
  output logic [$clog2(size)-1:0]         arr_rsel,
  output logic [$clog2(size)-1:0]         arr_csel,
  input  logic [nbits-1:0]                arr_data,
  output logic [nbits-1:0]                out_data,
  output logic [$clog2(size)-1:0]         out_row,
  output logic [$clog2(size)-1:0]         out_col,
  output logic                            out_val,
  input  logic                            out_rdy,
  output logic                            busy,
  output logic                            done
);

  localparam int sw = $clog2(size);
  localparam int bw = (nbeats > 1) ? $clog2(nbeats) : 1;
  localparam int dw = (drain > 1) ? $clog2(drain) : 1;
  localparam logic [sw-1:0] last_idx  = sw'(size - 1);
  localparam logic [bw-1:0] last_beat = bw'(nbeats - 1);

  typedef enum logic [1:0] {LOAD, DRAIN, READ} state_t;

  state_t          state;
  logic [bw-1:0]   beat_cnt;
  logic [dw-1:0]   drain_cnt;
  logic [sw-1:0]   r;
  logic [sw-1:0]   c;
  logic            armed;
  logic            beat_fire;
  logic            rd;
  logic            rd_fire;
  logic            last_elem;

  // armed is cleared by reset so in_rdy stays low while rst is asserted
  assign in_rdy    = armed && (state == LOAD) && arr_x_rdy && arr_w_rdy;
  assign beat_fire = in_rdy && in_val;
  assign arr_x_val = beat_fire;
  assign arr_w_val = beat_fire;
  assign arr_x_col = in_x_col;
  assign arr_w_row = in_w_row;

  assign rd        = (state == READ);
  assign arr_rsel  = rd ? r : '0;
  assign arr_csel  = rd ? c : '0;
  assign out_row   = rd ? r : '0;
  assign out_col   = rd ? c : '0;
  assign out_data  = rd ? arr_data : '0;
  assign rd_fire   = out_val && out_rdy;
  assign last_elem = (r == last_idx) && (c == last_idx);
  assign done      = rd_fire && last_elem;

  // drain_cnt counts down the DRAIN cycles left; the beat cycle itself counts as
  // the first drain cycle, so drain==1 goes straight to READ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LOAD;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      r         <= '0;
      c         <= '0;
      armed     <= 1'b0;
      busy      <= 1'b0;
      out_val   <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        LOAD: begin
          if (beat_fire) begin
            if (beat_cnt == last_beat) begin
              beat_cnt <= '0;
              busy     <= 1'b1;
              if (drain == 1) begin
                state   <= READ;
                out_val <= 1'b1;
                r       <= '0;
                c       <= '0;
              end else begin
                state     <= DRAIN;
                drain_cnt <= dw'(drain - 1);
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == dw'(1)) begin
            state     <= READ;
            out_val   <= 1'b1;
            drain_cnt <= '0;
            r         <= '0;
            c         <= '0;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        READ: begin
          if (rd_fire) begin
            if (last_elem) begin
              state   <= LOAD;
              out_val <= 1'b0;
              busy    <= 1'b0;
              r       <= '0;
              c       <= '0;
            end else if (c == last_idx) begin
              c <= '0;
              r <= r + 1'b1;
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        default: begin
          state   <= LOAD;
          out_val <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_seq.sv
// Bench for systolic_seq: a fake MAC array plus a job-level model checked every cycle,
// with directed jobs covering stalls, slow readout, ignored beats and mid-READ reset.
module tb_systolic_seq;
  localparam int S  = 4;
  localparam int NB = 4;
  localparam int DR = 10;
  localparam int NW = 16;

  logic clk, rst;
  logic [S-1:0][NW-1:0] in_x_col, in_w_row, arr_x_col, arr_w_row;
  logic in_val, in_rdy, arr_x_val, arr_x_rdy, arr_w_val, arr_w_rdy;
  logic [1:0] arr_rsel, arr_csel, out_row, out_col;
  logic [NW-1:0] arr_data, out_data;
  logic out_val, out_rdy, busy, done;

  systolic_seq #(.size(S), .nbits(NW), .nbeats(NB), .drain(DR)) dut (
    .clk(clk), .rst(rst), .in_x_col(in_x_col), .in_w_row(in_w_row), .in_val(in_val),
    .in_rdy(in_rdy), .arr_x_col(arr_x_col), .arr_x_val(arr_x_val), .arr_x_rdy(arr_x_rdy),
    .arr_w_row(arr_w_row), .arr_w_val(arr_w_val), .arr_w_rdy(arr_w_rdy),
    .arr_rsel(arr_rsel), .arr_csel(arr_csel), .arr_data(arr_data), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_val(out_val), .out_rdy(out_rdy),
    .busy(busy), .done(done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic fail_now(input string nm);
    n_total++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // fake array: accumulates outer products of pushed beats, cleared per job
  logic [NW-1:0] fa [S][S];
  int push_cnt = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < S; i++) for (int j = 0; j < S; j++) fa[i][j] <= '0;
    end else if (done) begin
      for (int i = 0; i < S; i++) for (int j = 0; j < S; j++) fa[i][j] <= '0;
    end else if (arr_x_val && arr_x_rdy && arr_w_val && arr_w_rdy) begin
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S; j++) fa[i][j] <= fa[i][j] + arr_x_col[i] * arr_w_row[j];
      push_cnt <= push_cnt + 1;
    end
  end
  assign arr_data = fa[arr_rsel][arr_csel];

  // job-level model
  bit m_loading;
  int m_beats, m_wait, m_idx, cyc, t_last, t_busy, t_val, done_cnt;
  int m_acc [S][S];
  int got [S][S];
  bit busy_q, val_q;

  always @(negedge clk) begin
    bit acc_ok, rd;
    int er, ec;
    if (!rst) begin
      m_loading = 1; m_beats = 0; m_wait = 0; m_idx = 0; busy_q = 0; val_q = 0;
      for (int i = 0; i < S; i++) for (int j = 0; j < S; j++) m_acc[i][j] = 0;
    end else begin
      cyc++;
      rd = !m_loading && m_wait == 0;
      er = rd ? m_idx / S : 0;
      ec = rd ? m_idx % S : 0;
      acc_ok = m_loading && arr_x_rdy && arr_w_rdy;
      chk("in_rdy", longint'(in_rdy), longint'(acc_ok));
      chk("arr_x_val", longint'(arr_x_val), longint'(acc_ok && in_val));
      chk("arr_w_val", longint'(arr_w_val), longint'(acc_ok && in_val));
      if (acc_ok && in_val) begin
        chk("arr_x_col", longint'(arr_x_col), longint'(in_x_col));
        chk("arr_w_row", longint'(arr_w_row), longint'(in_w_row));
      end
      chk("busy", longint'(busy), longint'(!m_loading));
      chk("out_val", longint'(out_val), longint'(rd));
      chk("done", longint'(done), longint'(rd && out_rdy && m_idx == S*S-1));
      chk("out_row", longint'(out_row), longint'(er));
      chk("out_col", longint'(out_col), longint'(ec));
      chk("arr_rsel", longint'(arr_rsel), longint'(er));
      chk("arr_csel", longint'(arr_csel), longint'(ec));
      chk("out_data", longint'(out_data), longint'(rd ? m_acc[er][ec] : 0));
      if (busy && !busy_q) t_busy = cyc;
      if (out_val && !val_q) t_val = cyc;
      busy_q = busy; val_q = out_val;
      if (m_loading) begin
        if (acc_ok && in_val) begin
          for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++)
              m_acc[i][j] = (m_acc[i][j] + int'(in_x_col[i]) * int'(in_w_row[j])) & 32'hffff;
          m_beats++;
          if (m_beats == NB) begin
            m_loading = 0; m_beats = 0; m_wait = DR - 1; t_last = cyc;
          end
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (out_rdy) begin
        got[er][ec] = int'(out_data);
        if (done) done_cnt++;
        m_idx++;
        if (m_idx == S*S) begin
          m_idx = 0; m_loading = 1;
          for (int i = 0; i < S; i++) for (int j = 0; j < S; j++) m_acc[i][j] = 0;
        end
      end
    end
  end

  logic [S-1:0][NW-1:0] jx [NB];
  logic [S-1:0][NW-1:0] jw [NB];

  task automatic load_set(input int set);
    for (int k = 0; k < NB; k++)
      for (int i = 0; i < S; i++) begin
        if (set == 1) begin
          jx[k][i] = NW'(i == k);
          jw[k][i] = NW'(k * S + i + 1);
        end else begin
          jx[k][i] = NW'(1);
          jw[k][i] = (i == 0) ? NW'(k + 1) : (i == 1) ? NW'(10) : (i == 2) ? NW'(0) : NW'(3);
        end
      end
  endtask

  task automatic send_beats(input bit stall, input bit junk);
    for (int k = 0; k < NB; k++) begin
      in_x_col = jx[k]; in_w_row = jw[k]; in_val = 1'b1;
      if (stall && k == 2) begin
        arr_x_rdy = 1'b0; arr_w_rdy = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        arr_x_rdy = 1'b1; arr_w_rdy = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_val = junk;
    in_x_col = '1; in_w_row = '1;
  endtask

  task automatic wait_out_val();
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (out_val) seen = 1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) fail_now("wait_out_val");
  endtask

  task automatic run_job(input bit stall, input bit slow, input bit junk);
    int pc0, dc0, p;
    bit seen;
    pc0 = push_cnt; dc0 = done_cnt;
    send_beats(stall, junk);
    wait_out_val();
    seen = 0; p = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      out_rdy = slow ? ((p % 3) == 0) : 1'b1;
      if (p == 6) in_val = 1'b0;
      @(negedge clk);
      if (done) seen = 1;
      @(posedge clk); #1;
      p++;
    end
    out_rdy = 1'b0; in_val = 1'b0;
    if (!seen) fail_now("wait_done");
    chk("in_rdy_after_done", longint'(in_rdy), 1);
    chk("pushes_per_job", longint'(push_cnt - pc0), NB);
    chk("done_per_job", longint'(done_cnt - dc0), 1);
  endtask

  initial begin
    bit found;
    int dc0;
    rst = 1'b0; in_val = 1'b0; in_x_col = '0; in_w_row = '0;
    arr_x_rdy = 1'b1; arr_w_rdy = 1'b1; out_rdy = 1'b0;
    #12;
    chk("rst_in_rdy", longint'(in_rdy), 0);
    chk("rst_out_val", longint'(out_val), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_rsel", longint'(arr_rsel), 0);
    chk("rst_csel", longint'(arr_csel), 0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    load_set(1);
    run_job(0, 0, 0);
    chk("busy_latency", longint'(t_busy - t_last), 1);
    chk("val_latency", longint'(t_val - t_last), DR);
    chk("job1_r0c0", longint'(got[0][0]), 1);
    chk("job1_r1c2", longint'(got[1][2]), 7);
    chk("job1_r2c1", longint'(got[2][1]), 10);
    chk("job1_r3c3", longint'(got[3][3]), 16);

    run_job(1, 0, 0);
    chk("stall_val_latency", longint'(t_val - t_last), DR);
    chk("stall_r1c2", longint'(got[1][2]), 7);
    chk("stall_r3c0", longint'(got[3][0]), 13);

    run_job(0, 1, 1);
    chk("slow_r0c3", longint'(got[0][3]), 4);
    chk("slow_r3c3", longint'(got[3][3]), 16);

    load_set(2);
    run_job(0, 0, 0);
    chk("job4_r0c0", longint'(got[0][0]), 10);
    chk("job4_r2c1", longint'(got[2][1]), 40);
    chk("job4_r1c2", longint'(got[1][2]), 0);
    chk("job4_r3c3", longint'(got[3][3]), 12);

    load_set(1);
    dc0 = done_cnt;
    send_beats(0, 0);
    wait_out_val();
    out_rdy = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (out_row == 2 && out_col == 1) found = 1;
      else begin @(posedge clk); #1; end
    end
    if (!found) fail_now("wait_elem_2_1");
    out_rdy = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_out_val", longint'(out_val), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_done", longint'(done), 0);
    chk("midrst_in_rdy", longint'(in_rdy), 0);
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", longint'(busy), 0);
    chk("post_rst_rsel", longint'(arr_rsel), 0);
    chk("post_rst_csel", longint'(arr_csel), 0);
    chk("post_rst_out_val", longint'(out_val), 0);
    chk("post_rst_in_rdy", longint'(in_rdy), 1);
    chk("post_rst_no_done", longint'(done_cnt - dc0), 0);

    load_set(2);
    run_job(0, 0, 0);
    chk("job6_r1c3", longint'(got[1][3]), 12);
    chk("job6_r3c0", longint'(got[3][0]), 10);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
